// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
// Provides the read-mode enum and the occupancy count width.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    // count must hold 0..DEPTH inclusive, hence one bit more than the pointer
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_fifo_ram.sv
// Storage array for param_fifo: synchronous write, asynchronous read.
// Ports: clock, we/waddr/wdata write port, raddr -> rdata read port.
module param_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with STD/FWFT read modes and flags.
// Ports: clock, resetn, clear, write_enb/data_in, read_enb/data_out,
//        empty, full, almost_empty, almost_full, count, overflow, underflow.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter int         AF_LEVEL   = DEPTH - 2,
    parameter int         AE_LEVEL   = 2,
    parameter fifo_mode_e MODE       = FIFO_STD
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     write_enb,
    input  logic                     read_enb,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of two >= 4");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("param_fifo: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("param_fifo: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rd_ok, wr_ok;
    logic [DATA_WIDTH-1:0] rdata;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // a pop frees a slot this edge, so a write into a full FIFO may proceed
    assign rd_ok = read_enb & ~empty;
    assign wr_ok = write_enb & (~full | rd_ok);

    param_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (wr_ok & ~clear),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
            ovf_d   = write_enb & ~wr_ok;
            unf_d   = read_enb & ~rd_ok;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (clear)      dout_d = '0;
            else if (rd_ok) dout_d = rdata;
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) dout_q <= '0;
            else         dout_q <= dout_d;
        end

        assign data_out = dout_q;
    end else begin : g_fwft
        // unwritten storage is masked while empty
        assign data_out = empty ? '0 : rdata;
    end

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: STD and FWFT instances share stimulus,
// a queue-based reference model predicts every post-edge output.
module tb_param_fifo;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = cnt_w(DEPTH);
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic we = 1'b0;
    logic re = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic s_emp, s_ful, s_ae, s_af, s_ovf, s_unf;
    logic f_emp, f_ful, f_ae, f_af, f_ovf, f_unf;
    logic [CW-1:0] s_cnt, f_cnt;

    always #5 clk = ~clk;

    param_fifo #(.MODE(FIFO_STD)) u_std (
        .clock(clk), .resetn(rst_n), .clear(clr),
        .write_enb(we), .read_enb(re), .data_in(din),
        .data_out(s_dout), .empty(s_emp), .full(s_ful),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf)
    );

    param_fifo #(.MODE(FIFO_FWFT)) u_fwft (
        .clock(clk), .resetn(rst_n), .clear(clr),
        .write_enb(we), .read_enb(re), .data_in(din),
        .data_out(f_dout), .empty(f_emp), .full(f_ful),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf)
    );

    typedef struct {
        int tgt;
        int cnt;
        int ovf;
        int unf;
        int dstd;
        int dfwft;
    } exp_t;

    exp_t eq[$];
    int   mq[$];
    int   std_d = 0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        nchk++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic push_exp(input int o, input int u);
        exp_t e;
        e.tgt   = cyc + 1;
        e.cnt   = mq.size();
        e.ovf   = o;
        e.unf   = u;
        e.dstd  = std_d;
        e.dfwft = (mq.size() > 0) ? mq[0] : 0;
        eq.push_back(e);
    endtask

    task automatic step(input bit w, input bit r, input bit c, input int d);
        bit rok, wok;
        int o, u;
        @(posedge clk);
        #1;
        we  = w;
        re  = r;
        clr = c;
        din = d[7:0];
        o = 0;
        u = 0;
        if (c) begin
            mq.delete();
            std_d = 0;
        end else begin
            rok = r && (mq.size() > 0);
            wok = w && (mq.size() < DEPTH || rok);
            if (rok) std_d = mq.pop_front();
            if (wok) mq.push_back(d & 'hFF);
            o = (w && !wok) ? 1 : 0;
            u = (r && !rok) ? 1 : 0;
        end
        push_exp(o, u);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_dout"}, s_dout, 0);
        chk({tag, "_s_cnt"},  s_cnt,  0);
        chk({tag, "_s_emp"},  s_emp,  1);
        chk({tag, "_s_ae"},   s_ae,   1);
        chk({tag, "_s_ful"},  s_ful,  0);
        chk({tag, "_s_af"},   s_af,   0);
        chk({tag, "_s_ovf"},  s_ovf,  0);
        chk({tag, "_s_unf"},  s_unf,  0);
        chk({tag, "_f_dout"}, f_dout, 0);
        chk({tag, "_f_cnt"},  f_cnt,  0);
        chk({tag, "_f_emp"},  f_emp,  1);
        chk({tag, "_f_af"},   f_af,   0);
    endtask

    // reset is asserted between edges, after the previous sample point
    task automatic reset_mid();
        @(posedge clk);
        #1;
        we  = 1'b0;
        re  = 1'b0;
        clr = 1'b0;
        #5;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        mq.delete();
        std_d = 0;
        push_exp(0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].tgt <= cyc) begin
            exp_t e;
            e = eq.pop_front();
            if (e.tgt < cyc) begin
                chk("missed_sample", e.tgt, cyc);
            end else begin
                chk("s_count", s_cnt, e.cnt);
                chk("s_empty", s_emp, e.cnt == 0);
                chk("s_full",  s_ful, e.cnt == DEPTH);
                chk("s_aempty", s_ae, e.cnt <= AE);
                chk("s_afull", s_af, e.cnt >= AF);
                chk("s_ovf", s_ovf, e.ovf);
                chk("s_unf", s_unf, e.unf);
                chk("s_dout", s_dout, e.dstd);
                chk("f_count", f_cnt, e.cnt);
                chk("f_afull", f_af, e.cnt >= AF);
                chk("f_ovf", f_ovf, e.ovf);
                chk("f_unf", f_unf, e.unf);
                chk("f_dout", f_dout, e.dfwft);
            end
        end
    end

    initial begin
        #1;
        chk_reset("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 1; i <= 16; i++) step(1, 0, 0, i);
        step(1, 0, 0, 'hAA);
        step(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        for (int i = 0; i < 16; i++) step(1, 0, 0, 'h20 + i);
        step(1, 1, 0, 'h55);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 'h77);
        step(0, 1, 0, 0);

        for (int i = 0; i < 3; i++) step(1, 0, 0, 'h80 + i);
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step(1, 0, 0, 'h83 + i / 2);
            else            step(0, 1, 0, 0);
        end
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        step(1, 0, 0, 'h3C);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);

        for (int i = 0; i < 9; i++) step(1, 0, 0, 'h90 + i);
        step(1, 0, 1, 'h99);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 'hB0 + i);
        reset_mid();

        for (int i = 0; i < 900; i++) begin
            int pw;
            bit w, r, c;
            pw = ((i / 60) % 2 == 1) ? 30 : 70;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < (100 - pw));
            c  = ($urandom_range(0, 79) == 0);
            if (i % 300 == 299) reset_mid();
            else step(w, r, c, $urandom_range(0, 255));
        end

        step(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #6;
        chk("queue_drained", eq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
